// File: rtl/md5_block_packetizer.sv
// Serialises one 512-bit MD5 block into a single credit-flow-controlled NoC packet.
// Flit 0 appears one cycle after accept; the block period is NUM_FLITS+1 cycles.
module md5_block_packetizer #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int VC_ID           = 0,
  parameter int BUF_DEPTH       = 8
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              blk_valid,
  output logic                                              blk_ready,
  input  logic [511:0]                                      message,
  input  logic [DEST_BITS-1:0]                              blk_dest,
  output logic [2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS-1:0]    flit_out,
  input  logic [VC_BITS:0]                                  credit_in,
  output logic                                              busy,
  output logic                                              credit_err
);

  localparam int NUM_FLITS = 512 / FLIT_DATA_WIDTH;
  localparam int IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_FLITS - 1);
  localparam logic [CNT_W-1:0]   FULL     = CNT_W'(BUF_DEPTH);
  localparam logic [VC_BITS-1:0] VC       = VC_BITS'(VC_ID);

  typedef enum logic [1:0] {S_RST, S_IDLE, S_SEND} state_t;

  state_t                                     state, state_nxt;
  logic [NUM_FLITS-1:0][FLIT_DATA_WIDTH-1:0]  msg_q;
  logic [DEST_BITS-1:0]                       dest_q;
  logic [IDX_W-1:0]                           idx;
  logic [CNT_W-1:0]                           credits;
  logic                                       accept;
  logic                                       send;
  logic                                       ret;
  logic                                       last;

  assign accept = (state == S_IDLE) && blk_valid;
  assign send   = (state == S_SEND) && (credits != '0);
  assign ret    = credit_in[VC_BITS] && (credit_in[VC_BITS-1:0] == VC);
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:   state_nxt = S_IDLE;
      S_IDLE:  if (blk_valid) state_nxt = S_SEND;
      S_SEND:  if (send && last) state_nxt = S_IDLE;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    blk_ready = (state == S_IDLE);
    busy      = (state == S_SEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q    <= '0;
      dest_q   <= '0;
      idx      <= '0;
      flit_out <= '0;
    end else begin
      if (accept) begin
        msg_q  <= message;
        dest_q <= blk_dest;
        idx    <= '0;
      end else if (send) begin
        idx <= last ? '0 : idx + IDX_W'(1);
      end
      // Word 0 (message[W-1:0]) leads so MD5 word M[0] is the head flit.
      flit_out <= send ? {1'b1, last, dest_q, VC, msg_q[idx]} : '0;
    end
  end

  // A send and a matching return on the same edge cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= FULL;
      credit_err <= 1'b0;
    end else if (send && !ret) begin
      credits <= credits - CNT_W'(1);
    end else if (ret && !send) begin
      if (credits == FULL) credit_err <= 1'b1;
      else                 credits    <= credits + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md5_block_packetizer.sv
// Directed bench for md5_block_packetizer at default parameters (32-bit flits, 16 per block, 8 credits).
module tb_md5_block_packetizer;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] message;
  logic [1:0]   blk_dest;
  logic [36:0]  flit_out;
  logic [1:0]   credit_in;
  logic         busy;
  logic         credit_err;

  int n_checks = 0;
  int n_pass   = 0;

  md5_block_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .message    (message),
    .blk_dest   (blk_dest),
    .flit_out   (flit_out),
    .credit_in  (credit_in),
    .busy       (busy),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [36:0] mk_flit(input logic tail, input logic [1:0] dest, input logic [31:0] data);
    return {1'b1, tail, dest, 1'b0, data};
  endfunction

  function automatic logic [511:0] mk_msg(input logic [31:0] base);
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = base + 32'(k);
    return m;
  endfunction

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    message   = '0;
    blk_dest  = '0;
    credit_in = '0;
    tick();
    tick();
    check("rst_ready", 64'(blk_ready), 64'd0);
    check("rst_flit",  64'(flit_out),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_err",   64'(credit_err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_state_ready", 64'(blk_ready), 64'd0);
    tick();
    check("idle_ready", 64'(blk_ready), 64'd1);

    // Block of all ones, one credit returned the cycle after each flit.
    message   = {512{1'b1}};
    blk_dest  = 2'd2;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    check("t1_ready_after_accept", 64'(blk_ready), 64'd0);
    check("t1_busy_after_accept",  64'(busy),      64'd1);
    check("t1_flit_after_accept",  64'(flit_out),  64'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check($sformatf("t1_flit%0d", k), 64'(flit_out), 64'(mk_flit(k == 15, 2'd2, 32'hFFFF_FFFF)));
      check($sformatf("t1_ready%0d", k), 64'(blk_ready), 64'(k == 15));
      credit_in = 2'b10;
    end
    tick();
    credit_in = '0;
    check("t1_idle_flit", 64'(flit_out), 64'd0);

    // Counting words, no credit returns: eight flits then stall.
    message   = mk_msg(32'd0);
    blk_dest  = 2'd1;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t2_flit%0d", k), 64'(flit_out), 64'(mk_flit(1'b0, 2'd1, 32'(k))));
    end
    tick();
    check("t2_stall_flit", 64'(flit_out), 64'd0);
    check("t2_stall_busy", 64'(busy),     64'd1);
    tick();
    check("t2_stall_flit2", 64'(flit_out), 64'd0);
    credit_in = 2'b10;
    tick();
    credit_in = '0;
    check("t2_ret_edge_flit", 64'(flit_out), 64'd0);
    tick();
    check("t2_flit8", 64'(flit_out), 64'(mk_flit(1'b0, 2'd1, 32'd8)));
    tick();
    check("t2_after8", 64'(flit_out), 64'd0);

    // Simultaneous send and return with one credit, then a wrong-vc return.
    credit_in = 2'b10;
    tick();
    check("t3_ret_flit", 64'(flit_out), 64'd0);
    tick();
    credit_in = '0;
    check("t3_flit9", 64'(flit_out), 64'(mk_flit(1'b0, 2'd1, 32'd9)));
    tick();
    check("t3_flit10", 64'(flit_out), 64'(mk_flit(1'b0, 2'd1, 32'd10)));
    tick();
    check("t3_empty", 64'(flit_out), 64'd0);
    credit_in = 2'b11;
    tick();
    credit_in = '0;
    check("t3_badvc_edge", 64'(flit_out), 64'd0);
    tick();
    check("t3_badvc_noflit", 64'(flit_out), 64'd0);

    // Drain the packet with a credit every cycle, then overfill the count.
    credit_in = 2'b10;
    tick();
    for (int k = 11; k < 16; k++) begin
      tick();
      check($sformatf("t3_flit%0d", k), 64'(flit_out), 64'(mk_flit(k == 15, 2'd1, 32'(k))));
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("t4_no_err%0d", k), 64'(credit_err), 64'd0);
    end
    tick();
    check("t4_err_set", 64'(credit_err), 64'd1);
    credit_in = '0;
    tick();
    check("t4_err_sticky", 64'(credit_err), 64'd1);

    // Back-to-back blocks with blk_valid held; inputs change right after accept.
    credit_in = 2'b10;
    message   = mk_msg(32'h1000);
    blk_dest  = 2'd3;
    blk_valid = 1'b1;
    tick();
    message  = mk_msg(32'h2000);
    blk_dest = 2'd1;
    for (int c = 1; c < 34; c++) begin
      logic [36:0] exp;
      tick();
      if (c <= 16)      exp = mk_flit(c == 16, 2'd3, 32'h1000 + 32'(c - 1));
      else if (c == 17) exp = '0;
      else              exp = mk_flit(c == 33, 2'd1, 32'h2000 + 32'(c - 18));
      check($sformatf("t5_flit_c%0d", c),  64'(flit_out),  64'(exp));
      check($sformatf("t5_ready_c%0d", c), 64'(blk_ready), 64'(c == 16 || c == 33));
    end
    blk_valid = 1'b0;
    credit_in = '0;
    tick();
    check("t5_idle_flit", 64'(flit_out), 64'd0);

    // Reset mid-packet after flit 5, then confirm credits are restored.
    message   = mk_msg(32'h3000);
    blk_dest  = 2'd2;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6_flit%0d", k), 64'(flit_out), 64'(mk_flit(1'b0, 2'd2, 32'h3000 + 32'(k))));
    end
    rst_n = 1'b0;
    #1;
    check("t6_rst_flit",  64'(flit_out),   64'd0);
    check("t6_rst_ready", 64'(blk_ready),  64'd0);
    check("t6_rst_busy",  64'(busy),       64'd0);
    check("t6_rst_err",   64'(credit_err), 64'd0);
    tick();
    check("t6_rst_hold_flit", 64'(flit_out), 64'd0);
    rst_n = 1'b1;
    #1;
    check("t6_rel_ready", 64'(blk_ready), 64'd0);
    tick();
    check("t6_idle_ready", 64'(blk_ready), 64'd1);
    message   = mk_msg(32'h4000);
    blk_dest  = 2'd0;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t6_new_flit%0d", k), 64'(flit_out), 64'(mk_flit(1'b0, 2'd0, 32'h4000 + 32'(k))));
    end
    tick();
    check("t6_new_stall", 64'(flit_out), 64'd0);
    check("t6_new_busy",  64'(busy),     64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md5_block_packetizer.md
# md5_block_packetizer

Injection stage between the MD5 message source and the CONNECT NoC send port. It accepts one 512-bit MD5 message block with a valid/ready handshake and serialises it into a single-packet train of flits on one user send port. Flow control uses the router's credit protocol: credits are counted locally and returned credits are absorbed. Its flit output connects directly to a `flit_in` send port of the generated network, and its credit input connects to the matching `credit_out`.

## Interface
- FLIT_DATA_WIDTH, 32: payload bits per flit; must divide 512. NUM_FLITS = 512/FLIT_DATA_WIDTH (16 at default).
- DEST_BITS, 2: width of the destination field (log2 of the number of receive ports).
- VC_BITS, 1: VC field width; 1 even for non-VC routers.
- VC_ID, 0: VC used for every flit and for credit matching.
- BUF_DEPTH, 8: router input-buffer depth; this is the initial and maximum credit count.
- Clk  in  1  system clock; all state updates on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- blk_valid  in  1  message block offered.
- blk_ready  out  1  block accepted on a posedge where blk_valid && blk_ready; reset 0, then 1 from the first edge after release.
- message  in  512  MD5 block; sampled on accept.
- blk_dest  in  DEST_BITS  destination receive port; sampled on accept.
- flit_out  out  2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS  packed {valid, tail, dest, vc, data}, MSB first; reset all-zero.
- credit_in  in  1+VC_BITS  {valid, vc}.
- busy  out  1  high while in SEND; reset 0.
- credit_err  out  1  sticky; set on a credit return while the count already equals BUF_DEPTH; reset 0.

## Operation
- States: RST (one cycle after reset release, blk_ready=0), IDLE, SEND.
- RST → IDLE unconditionally.
- IDLE: blk_ready=1. On accept:
  - latch message and blk_dest;
  - set idx=0;
  - go to SEND.
- SEND: blk_ready=0, busy=1. At each posedge where the registered credit count is > 0:
  - register a flit with valid=1, dest=latched dest, vc=VC_ID, data=message[idx*W +: W] (word 0 = bits [W-1:0] first, so MD5 word M[0] leads);
  - decrement credits and increment idx;
  - tail=1 only when idx==NUM_FLITS-1, and on that edge go to IDLE.
- When credits == 0 in SEND: flit_out is all-zero (valid=0) and idx holds.
- Outside SEND, flit_out is all-zero every cycle. No bubbles are inserted when credits are available.
- Credit accounting:
  - a return is credit_in valid=1 with vc==VC_ID; a return with a mismatched vc is ignored;
  - send and return on the same edge leave the count unchanged;
  - a return alone increments the count, saturating at BUF_DEPTH and setting credit_err;
  - the count width is $clog2(BUF_DEPTH+1).
- Credits persist across packets; only reset restores the count to BUF_DEPTH.
- Reset mid-packet:
  - all state returns to reset values immediately;
  - the partial packet is abandoned without a tail;
  - credits return to BUF_DEPTH (the network is reset by the same Rst_n).

## Timing
- Accept at edge E0 → flit 0 is visible after E1 → the last flit (tail) after E(NUM_FLITS), given sufficient credits.
- blk_ready rises after E(NUM_FLITS); the next accept is earliest at E(NUM_FLITS+1).
- Block period is NUM_FLITS+1 cycles (17 at default) with unlimited credit.
- A credit returned at edge Ec can be spent at edge Ec+1 at the earliest.
- blk_valid/message may change freely after accept; the latched copy is used.

## Test plan
- Reset then accept message = all-F, blk_dest=2, BUF_DEPTH=8, returning 1 credit per flit one cycle after each flit → 16 valid flits on consecutive cycles, each data=32'hFFFFFFFF, dest=2, vc=0, tail only on flit 15; blk_ready low for 16 cycles, then high.
- message = {16 words, word k = k}, no credits returned, BUF_DEPTH=8 → flits carry data 0..7 on 8 consecutive cycles; valid=0 thereafter with busy=1; returning 1 credit → exactly one more flit (data 8) two edges later.
- Credit return on the same edge as a send with count=1 → count stays 1, next cycle sends again; returning a credit with vc=1 → ignored, no flit when the count is 0.
- Credit return with count=BUF_DEPTH in IDLE → credit_err=1 and stays 1; count stays 8.
- Two back-to-back blocks with blk_valid held high → tails 17 cycles apart, second packet's data from the second message, blk_ready high for exactly one cycle between them.
- Rst_n low after flit 5 → flit_out=0, blk_ready=0, busy=0 during reset; after release, blk_ready=1 one cycle later; a new block sends 8 flits without credit returns (count restored).
